// File: rtl/contador_ad_bcd_2dig_param.sv
// Purpose: two-digit BCD up/down counter for one field of a settable display (e.g. hours/minutes),
//          with button auto-repeat, clamped load, and wrap or saturate at the limits.
// Latency: count/carry/borrow update one clock after the qualifying press edge or repeat tick;
//          digits are combinational from count.
// Backpressure: none; a step request is acted on in the cycle it is raised.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   en_count[3:0]       field select; this counter responds only when equal to FIELD_ID
//   enUP, enDOWN        level button inputs (held = auto-repeat every PRESCALE clocks)
//   load, load_val[6:0] one-cycle load strobe and binary value (clamped to [MIN_VAL, MAX_VAL])
//   count[6:0]          registered binary count
//   digit1, digit0      BCD tens / units of count
//   carry, borrow       one-cycle pulses on wrap MAX->MIN / MIN->MAX
module contador_ad_bcd_2dig_param #(
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 23,
  parameter int FIELD_ID = 10,
  parameter int WRAP     = 1,
  parameter int PRESCALE = 13000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] en_count,
  input  logic       enUP,
  input  logic       enDOWN,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [6:0] count,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       carry,
  output logic       borrow
);

  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [6:0]    MIN_C    = 7'(MIN_VAL);
  localparam logic [6:0]    MAX_C    = 7'(MAX_VAL);
  localparam logic [3:0]    SEL_ID   = 4'(FIELD_ID);

  logic [PW-1:0] presc;
  logic          up_q;
  logic          dn_q;
  // Low for the first cycle after reset: a button already held when reset
  // releases must not look like a fresh press.
  logic          edge_ok;

  logic       sel;
  logic       tick;
  logic       rise_up;
  logic       rise_dn;
  logic       step_up;
  logic       step_dn;
  logic [6:0] load_clamped;

  assign sel     = (en_count == SEL_ID);
  assign tick    = (presc == PRE_LAST);
  assign rise_up = enUP   & ~up_q & edge_ok;
  assign rise_dn = enDOWN & ~dn_q & edge_ok;

  // Both buttons pressed together cancel each other.
  assign step_up = sel & enUP   & ~enDOWN & (rise_up | tick);
  assign step_dn = sel & enDOWN & ~enUP   & (rise_dn | tick);

  always_comb begin
    load_clamped = load_val;
    if (load_val < MIN_C)      load_clamped = MIN_C;
    else if (load_val > MAX_C) load_clamped = MAX_C;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= MIN_C;
      carry   <= 1'b0;
      borrow  <= 1'b0;
      presc   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      edge_ok <= 1'b0;
    end else begin
      up_q    <= enUP;
      dn_q    <= enDOWN;
      edge_ok <= 1'b1;
      carry   <= 1'b0;
      borrow  <= 1'b0;

      // Restarting on a press makes the first repeat land exactly PRESCALE
      // clocks after the press instead of at a random phase.
      if (rise_up || rise_dn || tick) presc <= '0;
      else                            presc <= presc + 1'b1;

      if (load) begin
        count <= load_clamped;
      end else if (step_up) begin
        if (count == MAX_C) begin
          if (WRAP != 0) begin
            count <= MIN_C;
            carry <= 1'b1;
          end
        end else begin
          count <= count + 7'd1;
        end
      end else if (step_dn) begin
        if (count == MIN_C) begin
          if (WRAP != 0) begin
            count  <= MAX_C;
            borrow <= 1'b1;
          end
        end else begin
          count <= count - 7'd1;
        end
      end
    end
  end

  assign digit1 = 4'(count / 7'd10);
  assign digit0 = 4'(count % 7'd10);

endmodule

// File: tb/tb_contador_ad_bcd_2dig_param.sv
// Purpose: scoreboard bench for contador_ad_bcd_2dig_param over four parameterisations.
// Latency: expectations are queued one clock after each driven cycle and checked at the next falling edge.
// Backpressure: none; the monitor drains the queue every falling edge.
module tb_contador_ad_bcd_2dig_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-DUT stimulus and response
  logic       rst   [4];
  logic [3:0] enc   [4];
  logic       up    [4];
  logic       dn    [4];
  logic       ld    [4];
  logic [6:0] lv    [4];
  logic [6:0] cnt_o [4];
  logic [3:0] d1_o  [4];
  logic [3:0] d0_o  [4];
  logic       cy_o  [4];
  logic       bw_o  [4];

  // 0: defaults (slow prescaler)
  contador_ad_bcd_2dig_param u_a (
    .clk(clk), .reset(rst[0]), .en_count(enc[0]), .enUP(up[0]), .enDOWN(dn[0]),
    .load(ld[0]), .load_val(lv[0]), .count(cnt_o[0]), .digit1(d1_o[0]),
    .digit0(d0_o[0]), .carry(cy_o[0]), .borrow(bw_o[0]));

  // 1: fast prescaler, wrap
  contador_ad_bcd_2dig_param #(.PRESCALE(4)) u_b (
    .clk(clk), .reset(rst[1]), .en_count(enc[1]), .enUP(up[1]), .enDOWN(dn[1]),
    .load(ld[1]), .load_val(lv[1]), .count(cnt_o[1]), .digit1(d1_o[1]),
    .digit0(d0_o[1]), .carry(cy_o[1]), .borrow(bw_o[1]));

  // 2: fast prescaler, saturate
  contador_ad_bcd_2dig_param #(.PRESCALE(4), .WRAP(0)) u_c (
    .clk(clk), .reset(rst[2]), .en_count(enc[2]), .enUP(up[2]), .enDOWN(dn[2]),
    .load(ld[2]), .load_val(lv[2]), .count(cnt_o[2]), .digit1(d1_o[2]),
    .digit0(d0_o[2]), .carry(cy_o[2]), .borrow(bw_o[2]));

  // 3: range 1..59
  contador_ad_bcd_2dig_param #(.MIN_VAL(1), .MAX_VAL(59), .PRESCALE(4)) u_d (
    .clk(clk), .reset(rst[3]), .en_count(enc[3]), .enUP(up[3]), .enDOWN(dn[3]),
    .load(ld[3]), .load_val(lv[3]), .count(cnt_o[3]), .digit1(d1_o[3]),
    .digit0(d0_o[3]), .carry(cy_o[3]), .borrow(bw_o[3]));

  typedef struct {
    int         dut;
    string      tag;
    logic [6:0] cnt;
    logic       cy;
    logic       bw;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Drive one cycle of inputs to one DUT and queue the response expected after that edge.
  task automatic drive(input int d, input string tag, input logic [3:0] e, input logic u,
                       input logic w, input logic l, input logic [6:0] v, input logic r,
                       input logic [6:0] ec, input logic ecy, input logic ebw);
    exp_t x;
    @(negedge clk);
    rst[d] = r; enc[d] = e; up[d] = u; dn[d] = w; ld[d] = l; lv[d] = v;
    @(posedge clk);
    #1;
    x.dut = d; x.tag = tag; x.cnt = ec; x.cy = ecy; x.bw = ebw;
    sbq.push_back(x);
  endtask

  // Monitor: outputs are registered, so every falling edge presents a settled response.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t       e;
      logic [6:0] t1;
      logic [6:0] t0;
      e  = sbq.pop_front();
      t1 = e.cnt / 7'd10;
      t0 = e.cnt % 7'd10;
      n_cmp++;
      if (cnt_o[e.dut] !== e.cnt || d1_o[e.dut] !== t1[3:0] || d0_o[e.dut] !== t0[3:0] ||
          cy_o[e.dut] !== e.cy || bw_o[e.dut] !== e.bw) begin
        n_bad++;
        $display("FAIL %s: got count=%0d digits=%0d%0d carry=%b borrow=%b, want count=%0d digits=%0d%0d carry=%b borrow=%b",
                 e.tag, cnt_o[e.dut], d1_o[e.dut], d0_o[e.dut], cy_o[e.dut], bw_o[e.dut],
                 e.cnt, t1, t0, e.cy, e.bw);
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; enc[i] = 4'd0; up[i] = 1'b0; dn[i] = 1'b0; ld[i] = 1'b0; lv[i] = 7'd0;
    end
    repeat (2) @(posedge clk);

    //      dut tag             en  up dn ld val rst  count cy bw
    // Defaults: single press, select/both/load priority, wrap both ways
    drive(0, "A_reset",        0, 0, 0, 0,  0, 1,  0, 0, 0);
    drive(0, "A_idle",         0, 0, 0, 0,  0, 0,  0, 0, 0);
    drive(0, "A_press_up",    10, 1, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_release",     10, 0, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_no_repeat",   10, 0, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_deselected",   3, 1, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_desel_rel",    3, 0, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_both_btn",    10, 1, 1, 0,  0, 0,  1, 0, 0);
    drive(0, "A_both_rel",    10, 0, 0, 0,  0, 0,  1, 0, 0);
    drive(0, "A_load_vs_up",  10, 1, 0, 1,  7, 0,  7, 0, 0);
    drive(0, "A_after_load",  10, 0, 0, 0,  0, 0,  7, 0, 0);
    drive(0, "A_load_zero",   10, 0, 0, 1,  0, 0,  0, 0, 0);
    drive(0, "A_dn_wrap",     10, 0, 1, 0,  0, 0, 23, 0, 1);
    drive(0, "A_borrow_end",  10, 0, 0, 0,  0, 0, 23, 0, 0);
    drive(0, "A_up_wrap",     10, 1, 0, 0,  0, 0,  0, 1, 0);
    drive(0, "A_carry_end",   10, 0, 0, 0,  0, 0,  0, 0, 0);

    // PRESCALE=4: auto-repeat through wrap, deselect mid-hold, reset during hold
    drive(1, "B_reset",        0, 0, 0, 0,  0, 1,  0, 0, 0);
    drive(1, "B_idle",         0, 0, 0, 0,  0, 0,  0, 0, 0);
    drive(1, "B_load22",       0, 0, 0, 1, 22, 0, 22, 0, 0);
    drive(1, "B_press",       10, 1, 0, 0,  0, 0, 23, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, "B_hold_wait1", 10, 1, 0, 0, 0, 0, 23, 0, 0);
    drive(1, "B_tick_wrap",   10, 1, 0, 0,  0, 0,  0, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, "B_hold_wait2", 10, 1, 0, 0, 0, 0,  0, 0, 0);
    drive(1, "B_tick_2",      10, 1, 0, 0,  0, 0,  1, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, "B_desel_hold",  3, 1, 0, 0, 0, 0,  1, 0, 0);
    drive(1, "B_reset_hold",  10, 1, 0, 0,  0, 1,  0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, "B_no_edge",    10, 1, 0, 0, 0, 0,  0, 0, 0);
    drive(1, "B_first_tick",  10, 1, 0, 0,  0, 0,  1, 0, 0);

    // WRAP=0: saturate at both limits
    drive(2, "C_reset",        0, 0, 0, 0,  0, 1,  0, 0, 0);
    drive(2, "C_idle",         0, 0, 0, 0,  0, 0,  0, 0, 0);
    drive(2, "C_dn_at_min",   10, 0, 1, 0,  0, 0,  0, 0, 0);
    drive(2, "C_dn_rel",      10, 0, 0, 0,  0, 0,  0, 0, 0);
    drive(2, "C_load23",      10, 0, 0, 1, 23, 0, 23, 0, 0);
    drive(2, "C_up_at_max",   10, 1, 0, 0,  0, 0, 23, 0, 0);
    drive(2, "C_up_rel",      10, 0, 0, 0,  0, 0, 23, 0, 0);

    // MIN=1, MAX=59: reset value, load clamping, step inside range
    drive(3, "D_reset",        0, 0, 0, 0,  0, 1,  1, 0, 0);
    drive(3, "D_idle",         0, 0, 0, 0,  0, 0,  1, 0, 0);
    drive(3, "D_load75",       0, 0, 0, 1, 75, 0, 59, 0, 0);
    drive(3, "D_hold59",       0, 0, 0, 0,  0, 0, 59, 0, 0);
    drive(3, "D_load0",        0, 0, 0, 1,  0, 0,  1, 0, 0);
    drive(3, "D_load42",       0, 0, 0, 1, 42, 0, 42, 0, 0);
    drive(3, "D_up",          10, 1, 0, 0,  0, 0, 43, 0, 0);
    drive(3, "D_up_rel",      10, 0, 0, 0,  0, 0, 43, 0, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
